// File: rtl/wb_lfsr_multi.sv
// wb_lfsr_multi
//   Pipelined Wishbone slave (8-bit data) around a Fibonacci LFSR of
//   LFSR_W bits whose tap mask can be reprogrammed at run time. It
//   supports free-run and counted-step modes, byte-wide OUT reads that
//   advance the generator by 8 steps when idle, status flags, and
//   lock-up protection (a zero seed or zero tap mask is replaced by the
//   default).
//
//   Optional build macro: WB_LFSR_IRQ_EN adds o_irq = DONE | ZSEED.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_wb_cyc/stb/we     Wishbone request qualifiers
//   i_wb_addr[4:0]      byte register address
//   i_wb_data[7:0]      write data
//   o_wb_stall          high while the 8-step OUT generation runs
//   o_wb_data[7:0]      read data, valid with o_wb_ack
//   o_wb_ack            one-cycle acknowledge, cycle after accept
//   o_lfsr_bit          live MSB of the LFSR state
//   o_busy              stepping engine not idle
//   o_irq               (WB_LFSR_IRQ_EN only) DONE | ZSEED, registered
//
// Register map
//   0x00-0x07 SEED staging   0x08-0x0F TAPS staging
//   0x10 CTRL {STEP_GO,RUN,LOAD,SOFT_RST}   0x11 STEP count
//   0x12 STATUS {ZSEED,DONE,BUSY} (DONE/ZSEED W1C)   0x13 OUT
module wb_lfsr_multi #(
  parameter int unsigned         LFSR_W       = 32,
  parameter logic [LFSR_W-1:0]   DEFAULT_SEED = LFSR_W'(32'h00000001),
  parameter logic [LFSR_W-1:0]   DEFAULT_TAPS = LFSR_W'(32'h80200003)
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wb_cyc,
  input  logic       i_wb_stb,
  input  logic       i_wb_we,
  input  logic [4:0] i_wb_addr,
  input  logic [7:0] i_wb_data,
  output logic       o_wb_stall,
  output logic [7:0] o_wb_data,
  output logic       o_wb_ack,
  output logic       o_lfsr_bit,
  output logic       o_busy
`ifdef WB_LFSR_IRQ_EN
  ,
  output logic       o_irq
`endif
);

  localparam int unsigned NB = LFSR_W / 8;

  typedef enum logic [1:0] {
    S_HALT,
    S_RUN,
    S_STEP,
    S_GEN
  } fsm_t;

  fsm_t              fsm;
  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] taps;
  logic [LFSR_W-1:0] seed_stg;
  logic [LFSR_W-1:0] taps_stg;
  logic [7:0]        step_reg;
  logic [8:0]        cnt;
  logic              done;
  logic              zseed;

  logic              acc;
  logic              wr;
  logic              rd;
  logic              ctrl_wr;
  logic              status_wr;
  logic              step_wr;
  logic              stg_wr;
  logic              out_rd;
  logic              byte_ok;
  logic              load_go;
  logic              ctrl_redirect;
  logic              done_n;
  logic              zseed_n;
  logic [LFSR_W-1:0] stepped;
  logic [63:0]       seed_pad;
  logic [63:0]       taps_pad;
  logic [7:0]        rdata_c;

  // Stall is only raised by the OUT-triggered generation burst, so it is
  // a pure function of the registered FSM state.
  assign o_wb_stall = (fsm == S_GEN);
  assign o_busy     = (fsm != S_HALT);
  assign o_lfsr_bit = state[LFSR_W-1];

  assign acc       = i_wb_cyc & i_wb_stb & ~o_wb_stall;
  assign wr        = acc & i_wb_we;
  assign rd        = acc & ~i_wb_we;
  assign ctrl_wr   = wr && (i_wb_addr == 5'h10);
  assign step_wr   = wr && (i_wb_addr == 5'h11);
  assign status_wr = wr && (i_wb_addr == 5'h12);
  assign out_rd    = rd && (i_wb_addr == 5'h13);
  assign stg_wr    = wr && !i_wb_addr[4];
  assign byte_ok   = ({29'd0, i_wb_addr[2:0]} < NB);

  assign load_go       = ctrl_wr & i_wb_data[1] & ~i_wb_data[0];
  // A CTRL write that forces a new FSM state (soft reset or RUN) preempts
  // the natural end of a counted-step sequence, so DONE is not raised.
  assign ctrl_redirect = ctrl_wr & (i_wb_data[0] | i_wb_data[2]);

  assign stepped = {state[LFSR_W-2:0], ^(state & taps)};

  always_comb begin
    done_n  = done;
    zseed_n = zseed;
    if (status_wr) begin
      if (i_wb_data[1]) done_n  = 1'b0;
      if (i_wb_data[2]) zseed_n = 1'b0;
    end
    if (fsm == S_STEP && cnt == 9'd1 && !ctrl_redirect) done_n = 1'b1;
    if (load_go && seed_stg == '0) zseed_n = 1'b1;
  end

  always_comb begin
    seed_pad                = '0;
    taps_pad                = '0;
    seed_pad[LFSR_W-1:0]    = seed_stg;
    taps_pad[LFSR_W-1:0]    = taps_stg;
    rdata_c                 = '0;
    case (i_wb_addr)
      5'h10: rdata_c = {5'b0, (fsm == S_RUN), 2'b0};
      5'h11: rdata_c = step_reg;
      5'h12: rdata_c = {5'b0, zseed, done, (fsm != S_HALT)};
      5'h13: rdata_c = state[LFSR_W-1 -: 8];
      default: begin
        if (!i_wb_addr[4] && byte_ok) begin
          if (!i_wb_addr[3]) rdata_c = seed_pad[{i_wb_addr[2:0], 3'b000} +: 8];
          else               rdata_c = taps_pad[{i_wb_addr[2:0], 3'b000} +: 8];
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fsm       <= S_HALT;
      state     <= DEFAULT_SEED;
      taps      <= DEFAULT_TAPS;
      seed_stg  <= DEFAULT_SEED;
      taps_stg  <= DEFAULT_TAPS;
      step_reg  <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      zseed     <= 1'b0;
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
`ifdef WB_LFSR_IRQ_EN
      o_irq     <= 1'b0;
`endif
    end else begin
      o_wb_ack  <= acc;
      o_wb_data <= rd ? rdata_c : '0;
      done      <= done_n;
      zseed     <= zseed_n;
`ifdef WB_LFSR_IRQ_EN
      o_irq     <= done_n | zseed_n;
`endif

      for (int unsigned k = 0; k < NB; k++) begin
        if (stg_wr && i_wb_addr[2:0] == 3'(k)) begin
          if (!i_wb_addr[3]) seed_stg[8*k +: 8] <= i_wb_data;
          else               taps_stg[8*k +: 8] <= i_wb_data;
        end
      end
      if (step_wr) step_reg <= i_wb_data;

      // Natural FSM progress; a CTRL write below overrides it because the
      // later non-blocking assignment wins.
      case (fsm)
        S_HALT: begin
          if (out_rd) begin
            fsm <= S_GEN;
            cnt <= 9'd8;
          end
        end
        S_RUN: state <= stepped;
        S_STEP, S_GEN: begin
          state <= stepped;
          cnt   <= cnt - 9'd1;
          if (cnt == 9'd1) fsm <= S_HALT;
        end
        default: fsm <= S_HALT;
      endcase

      if (ctrl_wr) begin
        if (i_wb_data[0]) begin
          state <= DEFAULT_SEED;
          taps  <= DEFAULT_TAPS;
          fsm   <= S_HALT;
        end else begin
          if (i_wb_data[1]) begin
            state <= (seed_stg == '0) ? DEFAULT_SEED : seed_stg;
            taps  <= (taps_stg == '0) ? DEFAULT_TAPS : taps_stg;
          end
          if (i_wb_data[2]) begin
            fsm <= S_RUN;
          end else if (i_wb_data[3] && fsm != S_STEP) begin
            fsm <= S_STEP;
            cnt <= (step_reg == '0) ? 9'd256 : {1'b0, step_reg};
          end else if (fsm == S_RUN) begin
            fsm <= S_HALT;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_lfsr_multi.sv
// Bench for wb_lfsr_multi: a driver issues Wishbone requests and pushes
// the expected response into a scoreboard queue; a monitor pops and
// compares on every ack. Expected values come from a bit-level LFSR
// model using parity of (state & taps).
module tb_wb_lfsr_multi;

  localparam int unsigned W     = 32;
  localparam logic [31:0] DSEED = 32'h00000001;
  localparam logic [31:0] DTAPS = 32'h80200003;

  logic       clk = 1'b0;
  logic       reset;
  logic       cyc, stb, we;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       stall;
  logic [7:0] rdata;
  logic       ack;
  logic       lfsr_bit;
  logic       busy;
`ifdef WB_LFSR_IRQ_EN
  logic       irq;
`endif

  wb_lfsr_multi #(
    .LFSR_W      (W),
    .DEFAULT_SEED(DSEED),
    .DEFAULT_TAPS(DTAPS)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_wb_cyc  (cyc),
    .i_wb_stb  (stb),
    .i_wb_we   (we),
    .i_wb_addr (addr),
    .i_wb_data (wdata),
    .o_wb_stall(stall),
    .o_wb_data (rdata),
    .o_wb_ack  (ack),
    .o_lfsr_bit(lfsr_bit),
    .o_busy    (busy)
`ifdef WB_LFSR_IRQ_EN
    ,
    .o_irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    bit         is_rd;
    logic [7:0] data;
    int         acc_cyc;
    string      name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model
  logic [31:0] m_state, m_taps, m_seed_stg, m_taps_stg;
  bit          m_done, m_zseed;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] mstep(input logic [31:0] s, input logic [31:0] t, input int n);
    for (int i = 0; i < n; i++) s = {s[30:0], 1'($countones(s & t) % 2)};
    return s;
  endfunction

  // Monitor: every ack must match the oldest outstanding request.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack at cycle %0d", cyc_n);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.name, "_latency"}, 64'(cyc_n), 64'(mon_e.acc_cyc + 1));
        if (mon_e.is_rd) chk(mon_e.name, 64'(rdata), 64'(mon_e.data));
      end
    end
  end

  task automatic bus(input bit w, input logic [4:0] a, input logic [7:0] d,
                     input logic [7:0] expd, input string nm);
    int   guard;
    exp_t e;
    guard = 0;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
    while (stall === 1'b1 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 400) chk({nm, "_stall_timeout"}, 64'(guard), 64'd0);
    @(posedge clk); #1;
    e.is_rd   = !w;
    e.data    = expd;
    e.acc_cyc = cyc_n - 1;
    e.name    = nm;
    sbq.push_back(e);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus(1'b1, a, d, 8'h00, "write");
  endtask

  task automatic rdchk(input logic [4:0] a, input logic [7:0] expd, input string nm);
    bus(1'b0, a, 8'h00, expd, nm);
  endtask

  task automatic write_seed(input logic [31:0] s);
    for (int k = 0; k < 4; k++) wr(5'(k), s[8*k +: 8]);
    m_seed_stg = s;
  endtask

  task automatic write_taps(input logic [31:0] t);
    for (int k = 0; k < 4; k++) wr(5'(8 + k), t[8*k +: 8]);
    m_taps_stg = t;
  endtask

  task automatic do_load();
    wr(5'h10, 8'h02);
    m_state = (m_seed_stg == 0) ? DSEED : m_seed_stg;
    m_taps  = (m_taps_stg == 0) ? DTAPS : m_taps_stg;
    if (m_seed_stg == 0) m_zseed = 1;
  endtask

  task automatic read_out(input string nm);
    int n;
    rdchk(5'h13, m_state[31:24], nm);
    m_state = mstep(m_state, m_taps, 8);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall !== 1'b1) break;
      n++;
    end
    chk({nm, "_stall_cycles"}, 64'(n), 64'd8);
  endtask

  task automatic do_steps(input logic [7:0] n, input string nm);
    int b, want;
    want = (n == 0) ? 256 : int'(n);
    wr(5'h11, n);
    wr(5'h10, 8'h08);
    b = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      b++;
    end
    chk({nm, "_busy_cycles"}, 64'(b), 64'(want));
    m_state = mstep(m_state, m_taps, want);
    m_done  = 1;
  endtask

  function automatic logic [7:0] m_status();
    return {5'b0, m_zseed, m_done, 1'b0};
  endfunction

  task automatic model_reset();
    m_state = DSEED; m_taps = DTAPS;
    m_seed_stg = DSEED; m_taps_stg = DTAPS;
    m_done = 0; m_zseed = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, t;
    int          k;
    logic [7:0]  n;

    reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_data", 64'(rdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_bit", 64'(lfsr_bit), 64'(DSEED[31]));
    @(posedge clk); #1;
    reset = 1'b0;

    // T1
    rdchk(5'h00, 8'h01, "t1_seed0");
    rdchk(5'h10, 8'h00, "t1_ctrl");
    rdchk(5'h12, 8'h00, "t1_status");

    // T2
    write_seed(32'h64240F15);
    do_load();
    read_out("t2_out0");
    read_out("t2_out1");

    // Upper bytes and unmapped addresses
    wr(5'h05, 8'hAA);
    wr(5'h1F, 8'h55);
    rdchk(5'h05, 8'h00, "hi_seed_byte");
    rdchk(5'h0C, 8'h00, "hi_taps_byte");
    rdchk(5'h1F, 8'h00, "unmapped");
    rdchk(5'h09, m_taps_stg[15:8], "taps_stg1");

    // T3
    write_seed(32'h0);
    do_load();
    rdchk(5'h12, m_status(), "t3_status_z");
    wr(5'h12, 8'h04); m_zseed = 0;
    rdchk(5'h12, m_status(), "t3_status_clr");
    read_out("t3_out");

    // T4
    do_steps(8'd5, "t4_step5");
    rdchk(5'h12, m_status(), "t4_status_done");
    wr(5'h12, 8'h02); m_done = 0;
    read_out("t4_out5");
    do_steps(8'd0, "t4_step256");
    wr(5'h12, 8'h02); m_done = 0;
    read_out("t4_out256");

    // Randomized seeds, taps and step counts
    for (int it = 0; it < 6; it++) begin
      s = $urandom;
      t = $urandom;
      if (it == 2) t = 32'h0;
      write_seed(s);
      write_taps(t);
      do_load();
      read_out("rnd_out_a");
      n = 8'($urandom_range(1, 40));
      do_steps(n, "rnd_step");
      rdchk(5'h12, m_status(), "rnd_status");
      wr(5'h12, 8'h02); m_done = 0;
      read_out("rnd_out_b");
      k = $urandom_range(0, 3);
      rdchk(5'(k), m_seed_stg[8*k +: 8], "rnd_seed_stg");
      rdchk(5'h11, n, "rnd_step_reg");
    end

    // T5
    write_seed(32'hDEADBEEF);
    write_taps(32'h0);
    do_load();
    wr(5'h10, 8'h0F);
    m_state = DSEED; m_taps = DTAPS;
    @(negedge clk);
    chk("t5_softrst_busy", 64'(busy), 64'd0);
    read_out("t5_out_default");
    rdchk(5'h00, 8'hEF, "t5_stg_kept");
    wr(5'h10, 8'h06);
    @(negedge clk);
    chk("t5_run_busy", 64'(busy), 64'd1);
    rdchk(5'h10, 8'h04, "t5_ctrl_run");
    wr(5'h10, 8'h00);
    @(negedge clk);
    chk("t5_stop_busy", 64'(busy), 64'd0);
    // RUN while counting: switches to RUN, DONE stays clear
    wr(5'h11, 8'd100);
    wr(5'h10, 8'h08);
    wr(5'h10, 8'h04);
    rdchk(5'h10, 8'h04, "t5_step_to_run");
    wr(5'h10, 8'h00);
    rdchk(5'h12, m_status(), "t5_no_done");
    do_load();
    read_out("t5_resync");

    // T6: reset during GEN with a stalled request pending
    rdchk(5'h13, m_state[31:24], "t6_out");
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 5'h00;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("t6_ack", 64'(ack), 64'd0);
    chk("t6_stall", 64'(stall), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_bit", 64'(lfsr_bit), 64'(DSEED[31]));
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    rdchk(5'h00, 8'h01, "t6_seed_stg");
    rdchk(5'h11, 8'h00, "t6_step_reg");
    rdchk(5'h12, 8'h00, "t6_status");
    read_out("t6_out_default");

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
